// File: rtl/uart_pkg.sv
// Shared definitions for the rx_tx lab UART blocks (transmitter and receiver).
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam int unsigned UART_DATA_BITS    = 8;
  localparam int unsigned UART_FRAME_BITS   = 10;
  localparam int unsigned UART_DEF_CLK_FREQ = 100_000_000;
  localparam int unsigned UART_DEF_BAUD     = 9600;

  // Counter width for a divider; a width of at least one bit keeps degenerate dividers elaborating.
  function automatic int unsigned uart_cnt_width(input int unsigned clks);
    return (clks > 1) ? $clog2(clks) : 1;
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled and pulses bit_done on the last count.
module uart_baud_cnt
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned PRELOAD      = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic en,
  output logic bit_done
);

  localparam int unsigned         CNT_W = uart_cnt_width(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]    LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]    LOAD  = CNT_W'(PRELOAD);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // The receiver clears to a half-bit preload so it samples mid-bit; the transmitter clears to zero.
  always_comb begin
    cnt_d    = cnt_q;
    bit_done = 1'b0;
    if (clear) begin
      cnt_d = LOAD;
    end else if (en) begin
      if (cnt_q == LAST) begin
        cnt_d    = '0;
        bit_done = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: one byte per valid/ready handshake, sent LSB first on RsTx.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = UART_DEF_CLK_FREQ,
  parameter int unsigned BAUD     = UART_DEF_BAUD
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [UART_DATA_BITS-1:0] data,
  input  logic                      valid,
  output logic                      ready,
  output logic                      busy,
  output logic                      RsTx
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam logic [2:0]  LAST_IDX     = 3'(UART_DATA_BITS - 1);

  generate
    if (CLKS_PER_BIT < 2) begin : g_bad_divider
      $error("uart_tx: CLK_FREQ/BAUD must be at least 2");
    end
  endgenerate

  uart_state_e               state_q, state_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic [2:0]                idx_q, idx_d;
  logic                      tx_q, tx_d;
  logic                      ready_q, ready_d;
  logic                      busy_q, busy_d;
  logic                      cnt_clear;
  logic                      cnt_en;
  logic                      bit_done;

  // Counter is held at zero while idle so every frame starts from a clean bit period.
  always_comb begin
    cnt_clear = (state_q == IDLE);
    cnt_en    = (state_q != IDLE);
  end

  uart_baud_cnt #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .PRELOAD      (0)
  ) u_baud_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (cnt_clear),
    .en       (cnt_en),
    .bit_done (bit_done)
  );

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    tx_d    = tx_q;
    ready_d = ready_q;
    busy_d  = busy_q;
    unique case (state_q)
      IDLE: begin
        tx_d    = 1'b1;
        ready_d = 1'b1;
        busy_d  = 1'b0;
        if (valid && ready_q) begin
          shift_d = data;
          state_d = START;
          ready_d = 1'b0;
          busy_d  = 1'b1;
          tx_d    = 1'b0;
        end
      end
      START: begin
        if (bit_done) begin
          idx_d   = '0;
          state_d = DATA;
          tx_d    = shift_q[0];
        end
      end
      DATA: begin
        // The shift register owns the byte, so later changes on data cannot leak into the frame.
        if (bit_done) begin
          if (idx_q != LAST_IDX) begin
            idx_d   = idx_q + 3'd1;
            shift_d = {1'b0, shift_q[UART_DATA_BITS-1:1]};
            tx_d    = shift_q[1];
          end else begin
            state_d = STOP;
            tx_d    = 1'b1;
          end
        end
      end
      STOP: begin
        if (bit_done) begin
          state_d = IDLE;
          ready_d = 1'b1;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      tx_q    <= 1'b1;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      tx_q    <= tx_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  assign ready = ready_q;
  assign busy  = busy_q;
  assign RsTx  = tx_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: table vectors, randomized frames, a line monitor and a minimum-divider instance.
module tb_uart_tx;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] data;
  logic       valid;
  logic       ready, busy, tx;
  logic [7:0] data2;
  logic       valid2;
  logic       ready2, busy2, tx2;

  always #5 clk = ~clk;

  uart_tx #(.CLK_FREQ(1600), .BAUD(100)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .data  (data),
    .valid (valid),
    .ready (ready),
    .busy  (busy),
    .RsTx  (tx)
  );

  uart_tx #(.CLK_FREQ(200), .BAUD(100)) u_min (
    .clk   (clk),
    .rst_n (rst_n),
    .data  (data2),
    .valid (valid2),
    .ready (ready2),
    .busy  (busy2),
    .RsTx  (tx2)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int last_acc = 0;
  logic       mon_en = 1'b0;
  logic [8:0] mon_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] d;
    logic [9:0] frame;
    bit         hold;
    int         spacing;
    int         pulse_at;
    logic [7:0] pulse_d;
    int         rst_at;
  } vec_t;

  vec_t tbl[6];

  // Reference line image of one 8N1 frame, index 0 is the first bit on the wire.
  function automatic logic [9:0] frame_of(input logic [7:0] d);
    return {1'b1, d, 1'b0};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Offers one byte from a negedge and follows the line for the whole frame.
  task automatic send(input logic [7:0] d, input logic [9:0] exp, input string nm,
                      input bit hold, input int spacing, input int pulse_at,
                      input logic [7:0] pulse_d, input int rst_at, output bit aborted);
    int w;
    int b;
    logic [9:0] obs;
    aborted = 1'b0;
    w = 0;
    while (ready !== 1'b1 && w < 400) begin
      @(negedge clk);
      w++;
    end
    if (ready !== 1'b1) begin
      chk({nm, " ready_wait"}, 32'(ready), 32'd1);
      aborted = 1'b1;
      return;
    end
    data  = d;
    valid = 1'b1;
    obs   = '0;
    for (int k = 0; k < 10 * CPB; k++) begin
      @(negedge clk);
      b = k / CPB;
      if (k == 0) begin
        if (!hold) valid = 1'b0;
        chk({nm, " ready_after_accept"}, 32'(ready), 32'd0);
        chk({nm, " busy_after_accept"}, 32'(busy), 32'd1);
        if (spacing > 0) chk({nm, " accept_spacing"}, 32'(cyc - last_acc), 32'(spacing));
        last_acc = cyc;
      end
      if (k == pulse_at) begin
        data  = pulse_d;
        valid = 1'b1;
      end
      if (pulse_at >= 0 && k == pulse_at + 1) valid = 1'b0;
      if (k == rst_at) begin
        rst_n = 1'b0;
        #1;
        chk({nm, " rst_tx"}, 32'(tx), 32'd1);
        chk({nm, " rst_busy"}, 32'(busy), 32'd0);
        chk({nm, " rst_ready"}, 32'(ready), 32'd0);
        aborted = 1'b1;
        return;
      end
      if (k % CPB == 0 || tx !== exp[b]) obs[b] = tx;
    end
    for (int i = 0; i < 10; i++) chk($sformatf("%s bit%0d", nm, i), 32'(obs[i]), 32'(exp[i]));
    @(negedge clk);
    chk({nm, " ready_end"}, 32'(ready), 32'd1);
    chk({nm, " busy_end"}, 32'(busy), 32'd0);
    chk({nm, " idle_line"}, 32'(tx), 32'd1);
  endtask

  // Independent line decoder: samples each bit in its middle after a falling start edge.
  initial begin
    logic [7:0] mb;
    logic       ms;
    mb = '0;
    forever begin
      @(negedge clk);
      if (mon_en && tx === 1'b0) begin
        repeat (CPB / 2) @(negedge clk);
        if (tx === 1'b0) begin
          for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(negedge clk);
            mb[i] = tx;
          end
          repeat (CPB) @(negedge clk);
          ms = tx;
          mon_q.push_back({ms, mb});
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit         ab;
    logic [7:0] rd;
    int         gap;
    int         pat;
    logic [9:0] f2;
    logic [8:0] got;
    int         w;

    tbl[0] = '{8'hA5, 10'b1101001010, 1'b0, 0,   -1, 8'h00, -1};
    tbl[1] = '{8'h00, 10'b1000000000, 1'b1, 0,   -1, 8'h00, -1};
    tbl[2] = '{8'hFF, 10'b1111111110, 1'b0, 161, -1, 8'h00, -1};
    tbl[3] = '{8'h3C, 10'b1001111000, 1'b0, 161, 50, 8'hC3, -1};
    tbl[4] = '{8'h81, 10'b1100000010, 1'b0, 161, -1, 8'h00, 70};
    tbl[5] = '{8'h7E, 10'b1011111100, 1'b0, 0,   -1, 8'h00, -1};

    rst_n  = 1'b1;
    valid  = 1'b0;
    data   = 8'h00;
    valid2 = 1'b0;
    data2  = 8'h00;
    #2 rst_n = 1'b0;
    #1;
    chk("reset tx", 32'(tx), 32'd1);
    chk("reset ready", 32'(ready), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset min tx", 32'(tx2), 32'd1);
    chk("reset min ready", 32'(ready2), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("release ready before edge", 32'(ready), 32'd0);
    @(negedge clk);
    chk("release ready after edge", 32'(ready), 32'd1);
    chk("release busy", 32'(busy), 32'd0);

    for (int i = 0; i < 6; i++) begin
      send(tbl[i].d, tbl[i].frame, $sformatf("vec%0d", i), tbl[i].hold, tbl[i].spacing,
           tbl[i].pulse_at, tbl[i].pulse_d, tbl[i].rst_at, ab);
      if (tbl[i].rst_at >= 0) begin
        repeat (2) @(negedge clk);
        chk("in reset tx", 32'(tx), 32'd1);
        rst_n = 1'b1;
        #1;
        chk("rerelease ready before edge", 32'(ready), 32'd0);
        @(negedge clk);
        chk("rerelease ready after edge", 32'(ready), 32'd1);
        chk("rerelease tx", 32'(tx), 32'd1);
      end
    end

    for (int i = 0; i < 40; i++) begin
      rd  = 8'($urandom_range(0, 255));
      gap = $urandom_range(0, 4);
      pat = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 150) : -1;
      repeat (gap) @(negedge clk);
      send(rd, frame_of(rd), $sformatf("rand%0d", i), 1'b0, 161 + gap, pat,
           8'($urandom_range(0, 255)), -1, ab);
    end

    mon_en = 1'b1;
    for (int v = 0; v < 256; v++) begin
      send(8'(v), frame_of(8'(v)), $sformatf("loop%0d", v), 1'b1, 161, -1, 8'h00, -1, ab);
    end
    valid = 1'b0;
    repeat (5) @(negedge clk);
    mon_en = 1'b0;
    chk("loop frame count", 32'(mon_q.size()), 32'd256);
    for (int v = 0; v < 256; v++) begin
      if (mon_q.size() > 0) begin
        got = mon_q.pop_front();
        chk($sformatf("loop decode %0d", v), 32'(got[7:0]), 32'(v));
        chk($sformatf("loop stop %0d", v), 32'(got[8]), 32'd1);
      end
    end

    w = 0;
    while (ready2 !== 1'b1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("min ready idle", 32'(ready2), 32'd1);
    f2     = frame_of(8'h5A);
    data2  = 8'h5A;
    valid2 = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (k == 0) begin
        valid2 = 1'b0;
        chk("min ready after accept", 32'(ready2), 32'd0);
      end
      chk($sformatf("min line k%0d", k), 32'(tx2), 32'(f2[k / 2]));
      if (k == 19) chk("min busy last cycle", 32'(busy2), 32'd1);
    end
    @(negedge clk);
    chk("min ready end", 32'(ready2), 32'd1);
    chk("min busy end", 32'(busy2), 32'd0);
    chk("min idle line", 32'(tx2), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
